prefetch_fetch_unit: RTL

Parametrised instruction-fetch stage for the next-generation MIPS core.
- Replaces the single-cycle PC register and direct instruction-ROM read path.
- Decouples instruction memory from decode with a prefetch FIFO and a credit-limited request/response memory interface.
- Accepts branch/jump redirects from execute, flushes the FIFO and discards stale in-flight responses.

---
 rtl/prefetch_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, in-order tag queue, prefetch FIFO, redirect flush.
// Optional macro FETCH_BYPASS_EN: an empty FIFO forwards a live response to decode in the same cycle.
module prefetch_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Handshakes: a transfer happens in a cycle where valid and ready (imem_req/imem_ack,
    // inst_valid/inst_ready) are both high at the rising clock edge; valid never waits on ready.

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        credit_used;

    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
    logic [PTR_W-1:0]      tag_rd;
    logic [PTR_W-1:0]      tag_wr;
    logic [ADDR_WIDTH-1:0] tag_head;

    logic accept;
    logic live_rsp;
    logic fifo_empty;
    logic push;
    logic pop;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = !reset && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
    assign imem_addr   = fetch_pc;

    assign accept           = imem_req && imem_ack;
    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
    // Only responses to requests issued since the last redirect are live.
    assign live_rsp         = imem_rvalid && (discard == '0) && !redirect_valid;
    assign fifo_empty       = (count == '0);
    assign tag_head         = tag_q[tag_rd];
    assign pop              = !fifo_empty && inst_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass     = fifo_empty && live_rsp && !reset;
    assign inst_valid = !fifo_empty || bypass;
    assign inst_data  = bypass ? imem_rdata : fifo_data[rd_ptr];
    assign inst_pc    = bypass ? tag_head   : fifo_pc[rd_ptr];
    assign push       = live_rsp && !(bypass && inst_ready);
`else
    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign push       = live_rsp;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                discard  <= outstanding_next;
                tag_rd   <= '0;
                tag_wr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc      <= fetch_pc + ADDR_WIDTH'(4);
                    tag_q[tag_wr] <= fetch_pc;
                    tag_wr        <= tag_wr + PTR_W'(1);
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (live_rsp) begin
                    tag_rd <= tag_rd + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]   <= tag_head;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The credit check keeps count + outstanding <= DEPTH, so a full FIFO never sees a push.
    assert property (@(posedge clock) disable iff (reset) !(push && (count == DEPTH_C)));

endmodule
